// File: rtl/alu_md_unit_pkg.sv
// alu_md_unit_pkg
//   Shared definitions for the execute-stage ALU with its iterative
//   multiply/divide engine: operation codes, FSM state encodings, the
//   compact mul/div operation type and small decode helpers.
//   No ports (package).
package alu_md_unit_pkg;

  // Base ALU operation codes
  localparam logic [7:0] ALU_CTRL_ADD        = 8'h00;
  localparam logic [7:0] ALU_CTRL_SUB        = 8'h01;  // a - b
  localparam logic [7:0] ALU_CTRL_SUB2       = 8'h02;  // b - a
  localparam logic [7:0] ALU_CTRL_AND        = 8'h03;
  localparam logic [7:0] ALU_CTRL_OR         = 8'h04;
  localparam logic [7:0] ALU_CTRL_XOR        = 8'h05;
  localparam logic [7:0] ALU_CTRL_LSFT       = 8'h06;
  localparam logic [7:0] ALU_CTRL_RSFT       = 8'h07;
  localparam logic [7:0] ALU_CTRL_RSFTA      = 8'h08;
  localparam logic [7:0] ALU_CTRL_LESS_SIGN  = 8'h09;
  localparam logic [7:0] ALU_CTRL_GRTEQ_SIGN = 8'h0A;
  localparam logic [7:0] ALU_CTRL_LESS       = 8'h0B;
  localparam logic [7:0] ALU_CTRL_GRTEQ      = 8'h0C;
  localparam logic [7:0] ALU_CTRL_EQ         = 8'h0D;
  localparam logic [7:0] ALU_CTRL_NEQ        = 8'h0E;

  // Multiply/divide codes occupy 0x10..0x17 so bits [2:0] select the M op
  localparam logic [7:0] ALU_CTRL_MUL        = 8'h10;
  localparam logic [7:0] ALU_CTRL_MULH       = 8'h11;
  localparam logic [7:0] ALU_CTRL_MULHSU     = 8'h12;
  localparam logic [7:0] ALU_CTRL_MULHU      = 8'h13;
  localparam logic [7:0] ALU_CTRL_DIV        = 8'h14;
  localparam logic [7:0] ALU_CTRL_DIVU       = 8'h15;
  localparam logic [7:0] ALU_CTRL_REM        = 8'h16;
  localparam logic [7:0] ALU_CTRL_REMU       = 8'h17;

  // FSM state encodings
  localparam logic [1:0] ALU_MD_IDLE = 2'd0;
  localparam logic [1:0] ALU_MD_MUL  = 2'd1;
  localparam logic [1:0] ALU_MD_DIV  = 2'd2;

  // bit2 = divide family, bit1 (divide family) = remainder, bit0 (divide) = unsigned
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  function automatic logic is_muldiv(input logic [7:0] ctrl);
    return (ctrl[7:3] == 5'b00010);
  endfunction

  function automatic md_op_e to_md_op(input logic [7:0] ctrl);
    return md_op_e'(ctrl[2:0]);
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return op[2];
  endfunction

  // MUL only keeps the low half, which is identical for any signedness
  function automatic logic md_signed_a(input md_op_e op);
    logic s;
    case (op)
      MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM: s = 1'b1;
      default:                                   s = 1'b0;
    endcase
    return s;
  endfunction

  function automatic logic md_signed_b(input md_op_e op);
    logic s;
    case (op)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: s = 1'b1;
      default:                         s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_md_iter.sv
// alu_md_iter
//   Shared iterative multiply/divide datapath. Operands are converted to
//   magnitudes at start; the multiplier is a right-shifting shift-add that
//   retires MUL_BITS bits per cycle, the divider is a restoring divider
//   retiring one quotient bit per cycle. The sign fix-up is applied
//   combinationally on the last iteration so the result is ready together
//   with done.
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   abort       synchronous cancel of the operation in flight
//   start       load operands and begin (ignored while abort is high)
//   op          multiply/divide operation
//   a, b        operands (rs1, rs2)
//   done        high in the final cycle; result is valid in that cycle
//   result      final, sign-corrected result
module alu_md_iter import alu_md_unit_pkg::*; #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            abort,
  input  logic            start,
  input  md_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_BITS - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

  // hi_r: upper product / partial remainder, lo_r: multiplier / dividend-quotient
  logic            busy_r;
  md_op_e          op_r;
  logic [XLEN-1:0] hi_r;
  logic [XLEN-1:0] lo_r;
  logic [XLEN-1:0] opnd_r;
  logic            neg_r;
  logic            neg_rem_r;
  logic [CW-1:0]   cnt_r;

  logic            sa_s;
  logic            sb_s;
  logic [XLEN-1:0] mag_a_s;
  logic [XLEN-1:0] mag_b_s;

  assign sa_s    = md_signed_a(op) && a[XLEN-1];
  assign sb_s    = md_signed_b(op) && b[XLEN-1];
  assign mag_a_s = sa_s ? -a : a;
  assign mag_b_s = sb_s ? -b : b;

  // One multiply step: add multiplicand times the low multiplier bits, shift right
  logic [XLEN+MUL_BITS-1:0] pp_s;
  logic [XLEN+MUL_BITS-1:0] sum_s;
  logic [XLEN-1:0]          mul_hi_n_s;
  logic [XLEN-1:0]          mul_lo_n_s;

  assign pp_s       = {{MUL_BITS{1'b0}}, opnd_r} * {{XLEN{1'b0}}, lo_r[MUL_BITS-1:0]};
  assign sum_s      = {{MUL_BITS{1'b0}}, hi_r} + pp_s;
  assign mul_hi_n_s = sum_s[XLEN+MUL_BITS-1:MUL_BITS];
  assign mul_lo_n_s = {sum_s[MUL_BITS-1:0], lo_r[XLEN-1:MUL_BITS]};

  // One restoring divide step: shift in the next dividend bit, subtract if it fits
  logic [XLEN:0]   part_s;
  logic            fits_s;
  logic [XLEN-1:0] div_hi_n_s;
  logic [XLEN-1:0] div_lo_n_s;

  assign part_s     = {hi_r, lo_r[XLEN-1]};
  assign fits_s     = (part_s >= {1'b0, opnd_r});
  assign div_hi_n_s = fits_s ? XLEN'(part_s - {1'b0, opnd_r}) : part_s[XLEN-1:0];
  assign div_lo_n_s = {lo_r[XLEN-2:0], fits_s};

  logic [XLEN-1:0] hi_n_s;
  logic [XLEN-1:0] lo_n_s;

  assign hi_n_s = md_is_div(op_r) ? div_hi_n_s : mul_hi_n_s;
  assign lo_n_s = md_is_div(op_r) ? div_lo_n_s : mul_lo_n_s;
  assign done   = busy_r && (cnt_r == (md_is_div(op_r) ? DIV_LAST : MUL_LAST));

  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s;
  logic [XLEN-1:0]   rem_fix_s;

  // Sign fix-up of the value produced by the final step and result select
  always_comb begin
    prod_s     = {hi_n_s, lo_n_s};
    prod_fix_s = neg_r ? -prod_s : prod_s;
    quo_fix_s  = neg_r ? -lo_n_s : lo_n_s;
    rem_fix_s  = neg_rem_r ? -hi_n_s : hi_n_s;
    case (op_r)
      MD_MUL:                       result = prod_fix_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result = quo_fix_s;
      MD_REM, MD_REMU:              result = rem_fix_s;
      default:                      result = {XLEN{1'b0}};
    endcase
  end

  // Operand load, iteration and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r    <= 1'b0;
      op_r      <= MD_MUL;
      hi_r      <= {XLEN{1'b0}};
      lo_r      <= {XLEN{1'b0}};
      opnd_r    <= {XLEN{1'b0}};
      neg_r     <= 1'b0;
      neg_rem_r <= 1'b0;
      cnt_r     <= {CW{1'b0}};
    end else if (abort) begin
      busy_r <= 1'b0;
      cnt_r  <= {CW{1'b0}};
    end else if (start) begin
      busy_r    <= 1'b1;
      cnt_r     <= {CW{1'b0}};
      op_r      <= op;
      hi_r      <= {XLEN{1'b0}};
      neg_r     <= sa_s ^ sb_s;
      neg_rem_r <= sa_s;
      if (md_is_div(op)) begin
        lo_r   <= mag_a_s;
        opnd_r <= mag_b_s;
      end else begin
        lo_r   <= mag_b_s;
        opnd_r <= mag_a_s;
      end
    end else if (busy_r) begin
      hi_r <= hi_n_s;
      lo_r <= lo_n_s;
      if (done) begin
        busy_r <= 1'b0;
        cnt_r  <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/alu_md_unit.sv
// alu_md_unit
//   Execute-stage ALU with valid/ready handshakes. Base operations and the
//   trivial divide cases (divide by zero, signed overflow) produce a
//   registered result one cycle after acceptance; other multiply/divide
//   operations run on alu_md_iter with one operation in flight.
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous abort of in-flight op and pending result
//   in_valid/in_ready    input handshake; in_a, in_b, in_ctrl, in_tag payload
//   out_valid/out_ready  output handshake; out_y, out_tag payload
module alu_md_unit import alu_md_unit_pkg::*; #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [7:0]       in_ctrl,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_y,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ZERO_VAL = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_VAL = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       state_r;
  logic [TAG_W-1:0] tag_r;

  logic             accept_s;
  logic             is_md_s;
  md_op_e           md_op_s;
  logic             quick_s;
  logic             single_s;
  logic             start_iter_s;
  logic [XLEN-1:0]  base_y_s;
  logic [XLEN-1:0]  quick_y_s;
  logic [XLEN-1:0]  imm_y_s;
  logic             iter_done_s;
  logic [XLEN-1:0]  iter_result_s;
  logic [SHW-1:0]   shamt_s;

  // rst_n term keeps in_ready low while reset is asserted
  assign in_ready = rst_n && (state_r == ALU_MD_IDLE) && !flush && (!out_valid || out_ready);
  assign accept_s = in_valid && in_ready;
  assign is_md_s  = is_muldiv(in_ctrl);
  assign md_op_s  = to_md_op(in_ctrl);
  assign shamt_s  = in_b[SHW-1:0];

  // Single-cycle base ALU; unknown codes yield zero
  always_comb begin
    base_y_s = ZERO_VAL;
    case (in_ctrl)
      ALU_CTRL_ADD:        base_y_s = in_a + in_b;
      ALU_CTRL_SUB:        base_y_s = in_a - in_b;
      ALU_CTRL_SUB2:       base_y_s = in_b - in_a;
      ALU_CTRL_AND:        base_y_s = in_a & in_b;
      ALU_CTRL_OR:         base_y_s = in_a | in_b;
      ALU_CTRL_XOR:        base_y_s = in_a ^ in_b;
      ALU_CTRL_LSFT:       base_y_s = in_a << shamt_s;
      ALU_CTRL_RSFT:       base_y_s = in_a >> shamt_s;
      ALU_CTRL_RSFTA:      base_y_s = $signed(in_a) >>> shamt_s;
      ALU_CTRL_LESS_SIGN:  base_y_s = {{(XLEN-1){1'b0}}, ($signed(in_a) <  $signed(in_b))};
      ALU_CTRL_GRTEQ_SIGN: base_y_s = {{(XLEN-1){1'b0}}, ($signed(in_a) >= $signed(in_b))};
      ALU_CTRL_LESS:       base_y_s = {{(XLEN-1){1'b0}}, (in_a <  in_b)};
      ALU_CTRL_GRTEQ:      base_y_s = {{(XLEN-1){1'b0}}, (in_a >= in_b)};
      ALU_CTRL_EQ:         base_y_s = {{(XLEN-1){1'b0}}, (in_a == in_b)};
      ALU_CTRL_NEQ:        base_y_s = {{(XLEN-1){1'b0}}, (in_a != in_b)};
      default:             base_y_s = ZERO_VAL;
    endcase
  end

  // Divide special cases resolved without iterating: md_op_s[1] = remainder, [0] = unsigned
  always_comb begin
    quick_s   = 1'b0;
    quick_y_s = ZERO_VAL;
    if (is_md_s && md_is_div(md_op_s)) begin
      if (in_b == ZERO_VAL) begin
        quick_s   = 1'b1;
        quick_y_s = md_op_s[1] ? in_a : ONES_VAL;
      end else if (!md_op_s[0] && (in_a == MIN_VAL) && (in_b == ONES_VAL)) begin
        quick_s   = 1'b1;
        quick_y_s = md_op_s[1] ? ZERO_VAL : MIN_VAL;
      end else begin
        quick_s   = 1'b0;
        quick_y_s = ZERO_VAL;
      end
    end else begin
      quick_s   = 1'b0;
      quick_y_s = ZERO_VAL;
    end
  end

  assign single_s     = !is_md_s || quick_s;
  assign imm_y_s      = is_md_s ? quick_y_s : base_y_s;
  assign start_iter_s = accept_s && !single_s;

  alu_md_iter #(
    .XLEN     (XLEN),
    .MUL_BITS (MUL_BITS)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .abort  (flush),
    .start  (start_iter_s),
    .op     (md_op_s),
    .a      (in_a),
    .b      (in_b),
    .done   (iter_done_s),
    .result (iter_result_s)
  );

  // FSM: IDLE -> MUL/DIV on an iterating op, back to IDLE when its result is loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ALU_MD_IDLE;
      tag_r   <= {TAG_W{1'b0}};
    end else if (flush) begin
      state_r <= ALU_MD_IDLE;
    end else begin
      case (state_r)
        ALU_MD_IDLE: begin
          if (start_iter_s) begin
            state_r <= md_is_div(md_op_s) ? ALU_MD_DIV : ALU_MD_MUL;
            tag_r   <= in_tag;
          end
        end
        ALU_MD_MUL, ALU_MD_DIV: begin
          if (iter_done_s) begin
            state_r <= ALU_MD_IDLE;
          end
        end
        default: state_r <= ALU_MD_IDLE;
      endcase
    end
  end

  // Result register; flush drops any pending result, even one being consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_y     <= ZERO_VAL;
      out_tag   <= {TAG_W{1'b0}};
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept_s && single_s) begin
      out_valid <= 1'b1;
      out_y     <= imm_y_s;
      out_tag   <= in_tag;
    end else if ((state_r != ALU_MD_IDLE) && iter_done_s) begin
      out_valid <= 1'b1;
      out_y     <= iter_result_s;
      out_tag   <= tag_r;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
